id_ex_pipe_reg: RTL and testbench
=================================

// Module: id_ex_pipe_reg
// PURPOSE
//  ID/EX pipeline register of the MIPS core; sits directly upstream of ALU control and the ALU.
//  Latches decoded ID fields (ALU_op, funct, shamt, operands, regs, ctrl) for the EX stage.
//  Detects load-use hazards, stalls IF/ID and injects bubbles. Honours external stall and flush.
// PARAMETERS
//  NB_DATA  32  operand/immediate width
//  NB_REG   5   register index width
//  OPBITS   3   ALU_op width
//  FBITS    6   funct width
//  NB_CNT   16  bubble counter width (BUBBLE_COUNT_EN only)
// PORTS
//  i_clk         in   1        clock
//  i_reset       in   1        reset: one clock, synchronous, active-high
//  i_stall       in   1        external stall: hold all EX fields
//  i_flush       in   1        branch/jump flush: load bubble
//  i_valid       in   1        ID instruction valid
//  i_ALU_op      in   OPBITS   decoded ALU op class
//  i_funct       in   FBITS    instr[5:0]
//  i_shamt       in   NB_REG   instr[10:6]
//  i_rs_data     in   NB_DATA  rs read data
//  i_rt_data     in   NB_DATA  rt read data
//  i_imm         in   NB_DATA  extended immediate
//  i_rs/i_rt/i_rd in  NB_REG   register indices
//  i_ctrl        in   6        {reg_dst,ALU_src,mem_read,mem_write,mem_to_reg,reg_write}
//  o_valid       out  1        EX slot holds real instruction
//  o_ALU_op, o_funct, o_shamt, o_rs_data, o_rt_data, o_imm, o_rs, o_rt, o_rd, o_ctrl
//                out  (same widths)  registered copies of inputs
//  o_hazard_stall out 1        load-use stall to PC and IF/ID (combinational)
// BEHAVIOUR
//  - Latency 1 cycle ID->EX. Every output is a register except o_hazard_stall.
//  - Reset: all registered outputs are 0. Reset overrides all other inputs.
//  - Hazard: o_hazard_stall = o_valid & o_ctrl[3] & o_ctrl[0] & (o_rt!=0) & i_valid
//    & (o_rt==i_rs | o_rt==i_rt). Combinational from EX regs and ID inputs.
//  - Per-edge priority:
//    - reset: zero all.
//    - else i_flush: bubble.
//    - else i_stall: hold everything.
//    - else hazard: bubble.
//    - else i_valid: load.
//    - else: bubble.
//  - Bubble: o_valid=0, o_ctrl=0, o_ALU_op=3'b001 (add), all other fields 0.
//    No writes are possible from a bubble.
//  - Hazard lasts exactly 1 cycle. After the bubble loads, o_valid=0 and the stall drops.
//    The held ID instruction then loads on the next edge.
//  - The stall state keeps o_hazard_stall evaluating against the held regs.
//    The stall state does not clear o_hazard_stall.
//  - Flush during hazard: the bubble loads, and the hazard does not re-arm on that edge.
//  - No data transformation: widths pass through unchanged.
// CONFIGURATION
//  BUBBLE_COUNT_EN defined: adds output o_bubble_cnt [NB_CNT-1:0].
//    It increments on each edge that loads a bubble due to hazard or flush.
//    It does not count i_stall holds, reset, or idle (i_valid=0) bubbles.
//    It saturates at all-ones. It resets to 0.
//  BUBBLE_COUNT_EN undefined: the port and the counter are absent.
//    All other behaviour is identical.
// TESTING
//  1 Reset: i_reset=1 for 2 cycles with i_valid=1 and random fields.
//    -> all outputs 0, o_hazard_stall=0.
//  2 Load: ALU_op=000, funct=100000, rs=3, rt=4, rs_data=5, rt_data=7, ctrl=6'b100001.
//    -> next edge: outputs equal inputs, o_valid=1.
//  3 Load-use: edge N loads lw (ctrl=6'b011011, rt=8); ID presents add with rs=8.
//    -> o_hazard_stall=1 before edge N+1; bubble at N+1; stall=0; add loaded at N+2.
//  4 lw with rt=0, followed by use of rs=0.
//    -> o_hazard_stall stays 0, no bubble.
//  5 i_stall=1 for 3 cycles: EX fields held.
//    Then i_stall=1 and i_flush=1 together: bubble loads (o_valid=0, o_ctrl=0).
//  6 BUBBLE_COUNT_EN, NB_CNT=2: two hazards and two flushes.
//    -> o_bubble_cnt=3 (saturated). i_stall cycles and idle cycles do not increment it.

Source files
------------

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: latches decoded ID fields, detects load-use hazards, injects bubbles.
// Optional bubble counter enabled by defining BUBBLE_COUNT_EN.
module id_ex_pipe_reg #(
  parameter int NB_DATA = 32,
  parameter int NB_REG  = 5,
  parameter int OPBITS  = 3,
  parameter int FBITS   = 6
`ifdef BUBBLE_COUNT_EN
  ,
  parameter int NB_CNT  = 16
`endif
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_stall,
  input  logic               i_flush,
  input  logic               i_valid,
  input  logic [OPBITS-1:0]  i_ALU_op,
  input  logic [FBITS-1:0]   i_funct,
  input  logic [NB_REG-1:0]  i_shamt,
  input  logic [NB_DATA-1:0] i_rs_data,
  input  logic [NB_DATA-1:0] i_rt_data,
  input  logic [NB_DATA-1:0] i_imm,
  input  logic [NB_REG-1:0]  i_rs,
  input  logic [NB_REG-1:0]  i_rt,
  input  logic [NB_REG-1:0]  i_rd,
  input  logic [5:0]         i_ctrl,
  output logic               o_valid,
  output logic [OPBITS-1:0]  o_ALU_op,
  output logic [FBITS-1:0]   o_funct,
  output logic [NB_REG-1:0]  o_shamt,
  output logic [NB_DATA-1:0] o_rs_data,
  output logic [NB_DATA-1:0] o_rt_data,
  output logic [NB_DATA-1:0] o_imm,
  output logic [NB_REG-1:0]  o_rs,
  output logic [NB_REG-1:0]  o_rt,
  output logic [NB_REG-1:0]  o_rd,
  output logic [5:0]         o_ctrl,
  output logic               o_hazard_stall
`ifdef BUBBLE_COUNT_EN
  ,
  output logic [NB_CNT-1:0]  o_bubble_cnt
`endif
);

  typedef enum logic [1:0] {
    ACT_HOLD,
    ACT_LOAD,
    ACT_BUBBLE
  } act_t;

  logic               r_valid;
  logic [OPBITS-1:0]  r_ALU_op;
  logic [FBITS-1:0]   r_funct;
  logic [NB_REG-1:0]  r_shamt;
  logic [NB_DATA-1:0] r_rs_data;
  logic [NB_DATA-1:0] r_rt_data;
  logic [NB_DATA-1:0] r_imm;
  logic [NB_REG-1:0]  r_rs;
  logic [NB_REG-1:0]  r_rt;
  logic [NB_REG-1:0]  r_rd;
  logic [5:0]         r_ctrl;

  logic w_hazard;
  act_t w_act;

  // Load in EX (mem_read & reg_write) whose nonzero rt feeds a source of the ID instruction.
  always_comb begin
    w_hazard = r_valid & r_ctrl[3] & r_ctrl[0] & (r_rt != '0) & i_valid
             & ((r_rt == i_rs) | (r_rt == i_rt));
  end

  always_comb begin
    w_act = ACT_BUBBLE;
    if (i_flush)       w_act = ACT_BUBBLE;
    else if (i_stall)  w_act = ACT_HOLD;
    else if (w_hazard) w_act = ACT_BUBBLE;
    else if (i_valid)  w_act = ACT_LOAD;
    else               w_act = ACT_BUBBLE;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_valid   <= 1'b0;
      r_ALU_op  <= '0;
      r_funct   <= '0;
      r_shamt   <= '0;
      r_rs_data <= '0;
      r_rt_data <= '0;
      r_imm     <= '0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_rd      <= '0;
      r_ctrl    <= '0;
    end else begin
      case (w_act)
        ACT_LOAD: begin
          r_valid   <= 1'b1;
          r_ALU_op  <= i_ALU_op;
          r_funct   <= i_funct;
          r_shamt   <= i_shamt;
          r_rs_data <= i_rs_data;
          r_rt_data <= i_rt_data;
          r_imm     <= i_imm;
          r_rs      <= i_rs;
          r_rt      <= i_rt;
          r_rd      <= i_rd;
          r_ctrl    <= i_ctrl;
        end
        ACT_BUBBLE: begin
          // Bubble is an add with all control cleared, so it can never write.
          r_valid   <= 1'b0;
          r_ALU_op  <= OPBITS'(1);
          r_funct   <= '0;
          r_shamt   <= '0;
          r_rs_data <= '0;
          r_rt_data <= '0;
          r_imm     <= '0;
          r_rs      <= '0;
          r_rt      <= '0;
          r_rd      <= '0;
          r_ctrl    <= '0;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef BUBBLE_COUNT_EN
  logic [NB_CNT-1:0] r_bubble_cnt;
  logic              w_cnt_inc;

  // Only flush bubbles and hazard bubbles are counted; a stall hides the hazard.
  always_comb begin
    w_cnt_inc = i_flush | (~i_stall & w_hazard);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_bubble_cnt <= '0;
    end else if (w_cnt_inc && (r_bubble_cnt != '1)) begin
      r_bubble_cnt <= r_bubble_cnt + NB_CNT'(1);
    end
  end

  assign o_bubble_cnt = r_bubble_cnt;
`endif

  assign o_valid        = r_valid;
  assign o_ALU_op       = r_ALU_op;
  assign o_funct        = r_funct;
  assign o_shamt        = r_shamt;
  assign o_rs_data      = r_rs_data;
  assign o_rt_data      = r_rt_data;
  assign o_imm          = r_imm;
  assign o_rs           = r_rs;
  assign o_rt           = r_rt;
  assign o_rd           = r_rd;
  assign o_ctrl         = r_ctrl;
  assign o_hazard_stall = w_hazard;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed self-checking bench for id_ex_pipe_reg (define BUBBLE_COUNT_EN to cover the counter).
module tb_id_ex_pipe_reg;

  logic        clk = 1'b0;
  logic        i_reset, i_stall, i_flush, i_valid;
  logic [2:0]  i_ALU_op;
  logic [5:0]  i_funct;
  logic [4:0]  i_shamt, i_rs, i_rt, i_rd;
  logic [31:0] i_rs_data, i_rt_data, i_imm;
  logic [5:0]  i_ctrl;
  logic        o_valid, o_hazard_stall;
  logic [2:0]  o_ALU_op;
  logic [5:0]  o_funct, o_ctrl;
  logic [4:0]  o_shamt, o_rs, o_rt, o_rd;
  logic [31:0] o_rs_data, o_rt_data, o_imm;
`ifdef BUBBLE_COUNT_EN
  logic [1:0]  o_bubble_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

`ifdef BUBBLE_COUNT_EN
  id_ex_pipe_reg #(.NB_DATA(32), .NB_REG(5), .OPBITS(3), .FBITS(6), .NB_CNT(2)) dut (
`else
  id_ex_pipe_reg #(.NB_DATA(32), .NB_REG(5), .OPBITS(3), .FBITS(6)) dut (
`endif
    .i_clk(clk), .i_reset(i_reset), .i_stall(i_stall), .i_flush(i_flush), .i_valid(i_valid),
    .i_ALU_op(i_ALU_op), .i_funct(i_funct), .i_shamt(i_shamt),
    .i_rs_data(i_rs_data), .i_rt_data(i_rt_data), .i_imm(i_imm),
    .i_rs(i_rs), .i_rt(i_rt), .i_rd(i_rd), .i_ctrl(i_ctrl),
    .o_valid(o_valid), .o_ALU_op(o_ALU_op), .o_funct(o_funct), .o_shamt(o_shamt),
    .o_rs_data(o_rs_data), .o_rt_data(o_rt_data), .o_imm(o_imm),
    .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd), .o_ctrl(o_ctrl),
    .o_hazard_stall(o_hazard_stall)
`ifdef BUBBLE_COUNT_EN
    , .o_bubble_cnt(o_bubble_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input int exp);
`ifdef BUBBLE_COUNT_EN
    chk(tag, 64'(o_bubble_cnt), 64'(exp));
`endif
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [5:0] fn,
                       input logic [4:0] sh, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd,
                       input logic [31:0] imm, input logic [5:0] ctrl);
    i_valid = v; i_ALU_op = op; i_funct = fn; i_shamt = sh; i_rs = rs; i_rt = rt; i_rd = rd;
    i_rs_data = rsd; i_rt_data = rtd; i_imm = imm; i_ctrl = ctrl;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, ".valid"}, 64'(o_valid), 64'd0);
    chk({tag, ".ctrl"}, 64'(o_ctrl), 64'd0);
    chk({tag, ".op"}, 64'(o_ALU_op), 64'd1);
    chk({tag, ".rt"}, 64'(o_rt), 64'd0);
    chk({tag, ".rsd"}, 64'(o_rs_data), 64'd0);
  endtask

  initial begin
    // 1: reset for two cycles with random valid fields
    i_reset = 1'b1; i_stall = 1'b0; i_flush = 1'b0;
    drive(1'b1, 3'($urandom), 6'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
          5'($urandom), $urandom, $urandom, $urandom, 6'($urandom));
    tick(); tick();
    chk("rst.valid", 64'(o_valid), 64'd0);
    chk("rst.op", 64'(o_ALU_op), 64'd0);
    chk("rst.funct", 64'(o_funct), 64'd0);
    chk("rst.shamt", 64'(o_shamt), 64'd0);
    chk("rst.rsd", 64'(o_rs_data), 64'd0);
    chk("rst.rtd", 64'(o_rt_data), 64'd0);
    chk("rst.imm", 64'(o_imm), 64'd0);
    chk("rst.regs", 64'({o_rs, o_rt, o_rd}), 64'd0);
    chk("rst.ctrl", 64'(o_ctrl), 64'd0);
    chk("rst.haz", 64'(o_hazard_stall), 64'd0);
    chk_cnt("rst.cnt", 0);

    // 2: plain R-type load
    i_reset = 1'b0;
    drive(1'b1, 3'b000, 6'b100000, 5'd0, 5'd3, 5'd4, 5'd2, 32'd5, 32'd7, 32'h1234, 6'b100001);
    #1 chk("load.haz_pre", 64'(o_hazard_stall), 64'd0);
    tick();
    chk("load.valid", 64'(o_valid), 64'd1);
    chk("load.op", 64'(o_ALU_op), 64'd0);
    chk("load.funct", 64'(o_funct), 64'h20);
    chk("load.regs", 64'({o_rs, o_rt, o_rd}), 64'({5'd3, 5'd4, 5'd2}));
    chk("load.rsd", 64'(o_rs_data), 64'd5);
    chk("load.rtd", 64'(o_rt_data), 64'd7);
    chk("load.imm", 64'(o_imm), 64'h1234);
    chk("load.ctrl", 64'(o_ctrl), 64'b100001);

    // 3: load-use through rs
    drive(1'b1, 3'b000, 6'd0, 5'd0, 5'd1, 5'd8, 5'd0, 32'h100, 32'h0, 32'd4, 6'b011011);
    tick();
    chk("lw.ctrl", 64'(o_ctrl), 64'b011011);
    drive(1'b1, 3'b010, 6'b100000, 5'd0, 5'd8, 5'd9, 5'd10, 32'h11, 32'h22, 32'h0, 6'b100001);
    #1 chk("lu.haz", 64'(o_hazard_stall), 64'd1);
    tick();
    chk_bubble("lu.bub");
    chk("lu.haz_drop", 64'(o_hazard_stall), 64'd0);
    chk_cnt("lu.cnt", 1);
    tick();
    chk("lu.add.valid", 64'(o_valid), 64'd1);
    chk("lu.add.regs", 64'({o_rs, o_rt, o_rd}), 64'({5'd8, 5'd9, 5'd10}));
    chk("lu.add.op", 64'(o_ALU_op), 64'b010);

    // 4: load into $0 never stalls a consumer of $0
    drive(1'b1, 3'b000, 6'd0, 5'd0, 5'd2, 5'd0, 5'd0, 32'h0, 32'h0, 32'd8, 6'b011011);
    tick();
    drive(1'b1, 3'b000, 6'b100000, 5'd0, 5'd0, 5'd0, 5'd5, 32'h0, 32'h0, 32'h0, 6'b100001);
    #1 chk("r0.haz", 64'(o_hazard_stall), 64'd0);
    tick();
    chk("r0.valid", 64'(o_valid), 64'd1);
    chk("r0.rd", 64'(o_rd), 64'd5);

    // idle cycle: bubble, not counted
    i_valid = 1'b0;
    tick();
    chk_bubble("idle");
    chk_cnt("idle.cnt", 1);

    // 5: stall holds for three cycles, then stall+flush bubbles
    drive(1'b1, 3'b010, 6'h2A, 5'd5, 5'd11, 5'd12, 5'd13, 32'hAAAA5555, 32'h12345678,
          32'hFFFFFFF0, 6'b100001);
    tick();
    drive(1'b1, 3'b111, 6'h3F, 5'd31, 5'd21, 5'd22, 5'd23, 32'hDEADBEEF, 32'h0, 32'h1, 6'b110011);
    i_stall = 1'b1;
    for (int unsigned k = 0; k < 3; k++) tick();
    chk("stall.valid", 64'(o_valid), 64'd1);
    chk("stall.regs", 64'({o_rs, o_rt, o_rd}), 64'({5'd11, 5'd12, 5'd13}));
    chk("stall.data", {o_rs_data, o_rt_data}, {32'hAAAA5555, 32'h12345678});
    chk("stall.misc", 64'({o_ALU_op, o_funct, o_shamt, o_imm}), 64'({3'b010, 6'h2A, 5'd5, 32'hFFFFFFF0}));
    chk_cnt("stall.cnt", 1);
    i_flush = 1'b1;
    tick();
    chk_bubble("sflush");
    chk_cnt("sflush.cnt", 2);
    i_stall = 1'b0; i_flush = 1'b0;

    // hazard under stall holds; flush then clears it without re-arming
    drive(1'b1, 3'b000, 6'd0, 5'd0, 5'd1, 5'd8, 5'd0, 32'h0, 32'h0, 32'd4, 6'b011011);
    tick();
    drive(1'b1, 3'b000, 6'b100000, 5'd0, 5'd8, 5'd9, 5'd10, 32'h0, 32'h0, 32'h0, 6'b100001);
    i_stall = 1'b1;
    #1 chk("shaz.haz", 64'(o_hazard_stall), 64'd1);
    tick(); tick();
    chk("shaz.hold", 64'({o_ctrl, o_rt}), 64'({6'b011011, 5'd8}));
    chk("shaz.haz_kept", 64'(o_hazard_stall), 64'd1);
    chk_cnt("shaz.cnt", 2);
    i_stall = 1'b0; i_flush = 1'b1;
    tick();
    chk_bubble("hflush");
    chk("hflush.haz", 64'(o_hazard_stall), 64'd0);
    chk_cnt("hflush.cnt", 3);
    i_flush = 1'b0;
    tick();
    chk("hflush.add", 64'({o_valid, o_rs}), 64'({1'b1, 5'd8}));

    // second hazard through rt: counter already saturated
    drive(1'b1, 3'b000, 6'd0, 5'd0, 5'd1, 5'd8, 5'd0, 32'h0, 32'h0, 32'd4, 6'b011011);
    tick();
    drive(1'b1, 3'b000, 6'b100000, 5'd0, 5'd3, 5'd8, 5'd10, 32'h0, 32'h0, 32'h0, 6'b100001);
    #1 chk("rt.haz", 64'(o_hazard_stall), 64'd1);
    tick();
    chk_bubble("rt.bub");
    chk_cnt("sat.cnt", 3);
    tick();
    chk("rt.add", 64'({o_valid, o_rt, o_rd}), 64'({1'b1, 5'd8, 5'd10}));
    i_valid = 1'b0;
    tick();
    chk("idle2.valid", 64'(o_valid), 64'd0);
    chk_cnt("idle2.cnt", 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
